// File: rtl/key_entry_conditioner.sv
// Pushbutton front-end for the combination lock: 2-flop sync, debounce, chord reject, one strobe per press.
// Optional KEY_ENTRY_COUNT_EN adds a saturating entry_count output for the digit-progress display.
module key_entry_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_zero,
    input  logic       btn_one,
    output logic       update,
    output logic       key,
`ifdef KEY_ENTRY_COUNT_EN
    output logic [3:0] entry_count,
`endif
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_HELD,
        ST_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [1:0]       sync_zero;
    logic [1:0]       sync_one;
    logic [CNT_W-1:0] cnt;
    logic             cand;
    logic             s0;
    logic             s1;
    logic [1:0]       cand_hot;

    assign s0       = sync_zero[1];
    assign s1       = sync_one[1];
    assign cand_hot = cand ? 2'b10 : 2'b01;

    // NOTE: every register here uses <= so all flops sample pre-edge values, like real hardware.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_zero <= '0;
            sync_one  <= '0;
            state     <= ST_IDLE;
            cnt       <= '0;
            cand      <= 1'b0;
            update    <= 1'b0;
            key       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sync_zero <= {sync_zero[0], btn_zero};
            sync_one  <= {sync_one[0], btn_one};
            update    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    case ({s1, s0})
                        2'b01, 2'b10: begin
                            cand  <= s1;
                            cnt   <= '0;
                            state <= ST_DEBOUNCE;
                            busy  <= 1'b1;
                        end
                        2'b11: begin
                            cnt   <= '0;
                            state <= ST_HELD;
                            busy  <= 1'b1;
                        end
                        default: ;
                    endcase
                end

                ST_DEBOUNCE: begin
                    if ({s1, s0} == cand_hot) begin
                        if (cnt == CNT_LAST) begin
                            cnt    <= '0;
                            state  <= ST_EMIT;
                            update <= 1'b1;
                            key    <= cand;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        // Bounce, release or a second button: start over without a strobe.
                        cnt   <= '0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                ST_EMIT: begin
                    cnt   <= '0;
                    state <= ST_HELD;
                end

                ST_HELD: begin
                    if (!s0 && !s1) begin
                        cnt   <= '0;
                        state <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (!s0 && !s1) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cnt   <= '0;
                        state <= ST_HELD;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef KEY_ENTRY_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_count <= '0;
        end else if (state == ST_EMIT && entry_count != 4'd15) begin
            entry_count <= entry_count + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_key_entry_conditioner.sv
// Directed bench for key_entry_conditioner with DEBOUNCE_CYCLES=4; expected values are hand-derived.
module tb_key_entry_conditioner;

    localparam int DEB = 4;

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic btn_zero = 1'b0;
    logic btn_one  = 1'b0;
    logic update;
    logic key;
    logic busy;
`ifdef KEY_ENTRY_COUNT_EN
    logic [3:0] entry_count;
`endif

    int         vectors     = 0;
    int         miscompares = 0;
    int         strobes     = 0;
    logic       last_key    = 1'b0;
    logic       prev_update = 1'b0;
    logic [4:0] lock_hist   = '0;

    always #5 clk = ~clk;

    key_entry_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_zero   (btn_zero),
        .btn_one    (btn_one),
        .update     (update),
        .key        (key),
`ifdef KEY_ENTRY_COUNT_EN
        .entry_count(entry_count),
`endif
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clocks, sampling 1 ns after each edge and logging every strobe.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (update === 1'b1) begin
                check("strobe_width", {31'b0, prev_update}, 32'd0);
                strobes++;
                last_key  = key;
                lock_hist = {lock_hist[3:0], key};
            end
            prev_update = update;
        end
    endtask

    initial begin
        int k;
        int base;
        logic [4:0] seq;

        // Reset with btn_one held; release reset so the next edge is E0.
        btn_one = 1'b1;
        #23;
        check("rst_update", update, 0);
        check("rst_key", key, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        k = 0;
        while (strobes == 0 && k < 40) begin
            tick(1);
            k++;
        end
        check("press_latency_edges", k, DEB + 3);
        check("held_key", last_key, 1);
        check("held_busy", busy, 1);
        tick(1);
        check("strobe_dropped", update, 0);
        btn_one = 1'b0;
        tick(20);
        check("held_idle_busy", busy, 0);
        check("held_strobes", strobes, 1);

        // Clean btn_zero press, then release timing of busy.
        base = strobes;
        btn_zero = 1'b1;
        tick(40);
        check("zero_strobes", strobes, base + 1);
        check("zero_key", last_key, 0);
        check("zero_busy_held", busy, 1);
        btn_zero = 1'b0;
        tick(DEB + 2);
        check("release_busy_still", busy, 1);
        tick(1);
        check("release_busy_clear", busy, 0);
        check("release_no_strobe", strobes, base + 1);

        // Bouncing btn_one: no strobe until it holds still.
        base = strobes;
        for (int p = 0; p < 5; p++) begin
            btn_one = 1'b1;
            tick(2);
            btn_one = 1'b0;
            tick(2);
        end
        check("bounce_no_strobe", strobes, base);
        btn_one = 1'b1;
        tick(10);
        check("bounce_then_strobe", strobes, base + 1);
        check("bounce_key", last_key, 1);
        btn_one = 1'b0;
        tick(12);

        // Chord: both rise together, never emitted.
        base = strobes;
        btn_zero = 1'b1;
        btn_one  = 1'b1;
        tick(20);
        check("chord_no_strobe", strobes, base);
        check("chord_busy", busy, 1);
        btn_zero = 1'b0;
        btn_one  = 1'b0;
        tick(12);
        check("chord_release_busy", busy, 0);
        btn_zero = 1'b1;
        tick(10);
        check("after_chord_strobe", strobes, base + 1);
        check("after_chord_key", last_key, 0);
        btn_zero = 1'b0;
        tick(12);

        // Fresh reset, then lock combination 0,1,0,1,1.
        reset_n = 1'b0;
        tick(2);
        reset_n   = 1'b1;
        lock_hist = '0;
        base      = strobes;
        seq       = 5'b01011;
        for (int i = 0; i < 5; i++) begin
            btn_zero = ~seq[4-i];
            btn_one  = seq[4-i];
            tick(10);
            check("seq_strobes", strobes, base + i + 1);
            check("seq_key", last_key, seq[4-i]);
            btn_zero = 1'b0;
            btn_one  = 1'b0;
            tick(10);
        end
        check("lock_unlock", lock_hist == 5'b01011, 1);
`ifdef KEY_ENTRY_COUNT_EN
        check("entry_count", entry_count, 5);
`endif

        // Reset in the middle of debouncing a btn_one press.
        base = strobes;
        btn_one = 1'b1;
        tick(4);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_update", update, 0);
        check("abort_key", key, 0);
        check("abort_busy", busy, 0);
`ifdef KEY_ENTRY_COUNT_EN
        check("abort_entry_count", entry_count, 0);
`endif
        tick(3);
        check("abort_no_strobe", strobes, base);
        reset_n = 1'b1;
        tick(10);
        check("post_reset_press", strobes, base + 1);
        check("post_reset_key", last_key, 1);
        btn_one = 1'b0;
        tick(12);
        check("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
